alu_slice_sequencer: RTL and testbench
======================================

# alu_slice_sequencer

Multi-cycle controller that runs a W-bit operation (W = 4·NIBBLES) through the model computer's single 4-bit 74181-style ALU slice, one nibble per clock, least significant first. It sits on both sides of the slice: it drives the slice's A/B/S/M/C0 inputs from latched operands and collects F/C4 back into a result register. It exposes a start/busy/done handshake to the control unit and hands the assembled result and flags to the datapath.

## Interface
- NIBBLES, default 4: number of 4-bit slices per operation; W = 4·NIBBLES.
- clk  in  1  rising-edge clock; sole clock domain.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- opa  in  W  operand A; latched on accepted start.
- opb  in  W  operand B; latched on accepted start.
- s  in  4  74181 function select; latched on accepted start.
- m  in  1  mode, 1 = logic, 0 = arithmetic; latched on accepted start.
- cin  in  1  carry-in, active-low (0 = +1); latched on accepted start.
- alu_a  out  4  current nibble of latched A.
- alu_b  out  4  current nibble of latched B.
- alu_s  out  4  latched s.
- alu_m  out  1  latched m.
- alu_c0  out  1  carry into current slice, active-low.
- alu_f  in  4  slice result, combinational from alu_* outputs.
- alu_c4  in  1  slice carry-out, active-low.
- result  out  W  assembled result; held until next accepted start.
- cout  out  1  final slice carry-out, active-low.
- zero  out  1  result == 0.
- busy  out  1  high while nibbles are processed.
- done  out  1  one-cycle pulse when result/flags are valid.
- ovf  out  1  signed overflow (only with ALU_SEQ_OVF_EN).

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 → latch opa, opb, s, m, cin into registers; idx ← 0; carry register ← cin; go RUN.
- RUN: alu_a/alu_b = latched operand bits [4·idx+3:4·idx]; alu_c0 = carry register. Each clock: result[4·idx+3:4·idx] ← alu_f; carry register ← alu_c4; idx ← idx+1. After idx = NIBBLES−1, go DONE.
- Carry chaining: alu_c4 is fed unmodified to the next alu_c0 (both active-low). In logic mode the chain still runs; the slice ignores it.
- DONE: done=1 for one cycle; cout ← final carry register; zero ← (result == 0); go IDLE.
- start in RUN or DONE: ignored, no queuing.
- result, cout, zero, ovf hold their values in IDLE until the next DONE. result nibbles are overwritten progressively during RUN. Consumers read them only on done.
- idx width = clog2(NIBBLES), minimum 1 bit. NIBBLES = 1 is legal: one RUN cycle.

## Timing
- Reset (rst_n=0 at a rising edge) → state IDLE, idx 0, all latches 0, carry register 1, result 0, cout 1, zero 0, busy 0, done 0, ovf 0. Consequently alu_a=0, alu_b=0, alu_s=0, alu_m=0, alu_c0=1.
- Reset mid-RUN or in DONE aborts the operation: no done pulse, and outputs take the reset values above.
- Start sampled at edge 0 → busy=1 in cycles 1..NIBBLES → done=1 in cycle NIBBLES+1 → busy=0 from cycle NIBBLES+1.
- A new start can be accepted at the first edge after done (back-to-back throughput of one operation per NIBBLES+2 cycles).
- The slice path alu_* → alu_f/alu_c4 is combinational within one cycle and must meet a single-cycle timing budget.

## Configuration
- ALU_SEQ_OVF_EN defined: port ovf exists and is updated in DONE. Only the MSB slice's sign bits matter.
  - Add case (m=0, s=1001): ovf = (a_msb == b_msb) & (f_msb != a_msb).
  - Subtract case (m=0, s=0110): ovf = (a_msb != b_msb) & (f_msb != a_msb).
  - All other functions: ovf = 0.
- ALU_SEQ_OVF_EN undefined: port ovf and its logic are absent. All other behaviour is identical.

## Test plan
- Add, NIBBLES=4: opa=0x1234, opb=0x0FFF, s=1001, m=0, cin=1, start at edge 0 → done in cycle 5; result=0x2233, cout=1, zero=0.
- Ripple carry: 0xFFFF + 0x0001, s=1001, m=0, cin=1 → result=0x0000, zero=1, cout=0. alu_c0 is observed as 1,0,0,0 across RUN cycles.
- Subtract: opa=0x5000, opb=0x0001, s=0110, m=0, cin=0 → result=0x4FFF, cout=0.
- Logic XOR: opa=0xF0F0, opb=0xFF00, s=0110, m=1 → result=0x0FF0. A start pulse in cycle 2 is ignored; busy stays high through cycle 4 and there is exactly one done pulse.
- Reset mid-op: start an add, drive rst_n=0 in cycle 2 → next cycle busy=0, result=0, alu_c0=1, and no done pulse. A following start completes normally.
- ALU_SEQ_OVF_EN: 0x7FFF + 0x0001, s=1001, m=0, cin=1 → result=0x8000, ovf=1. Then 0x0001 + 0x0001 → ovf=0.

Source files
------------

// File: rtl/alu_slice_sequencer.sv
// Sequences a W-bit operation through one 4-bit 74181-style slice, one nibble per clock, LSB first.
// Optional signed-overflow flag on port ovf when ALU_SEQ_OVF_EN is defined.
module alu_slice_sequencer #(
  parameter int unsigned NIBBLES = 4,
  localparam int unsigned W = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] opa,
  input  logic [W-1:0] opb,
  input  logic [3:0]   s,
  input  logic         m,
  input  logic         cin,
  output logic [3:0]   alu_a,
  output logic [3:0]   alu_b,
  output logic [3:0]   alu_s,
  output logic         alu_m,
  output logic         alu_c0,
  input  logic [3:0]   alu_f,
  input  logic         alu_c4,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         zero,
  output logic         busy,
  output logic         done
`ifdef ALU_SEQ_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [W-1:0]    opa_q, opa_d;
  logic [W-1:0]    opb_q, opb_d;
  logic [3:0]      s_q, s_d;
  logic            m_q, m_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    result_q, result_d;
  logic            cout_q, cout_d;
  logic            zero_q, zero_d;
`ifdef ALU_SEQ_OVF_EN
  logic            ovf_q, ovf_d;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      s_q      <= '0;
      m_q      <= 1'b0;
      carry_q  <= 1'b1;
      result_q <= '0;
      cout_q   <= 1'b1;
      zero_q   <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      s_q      <= s_d;
      m_q      <= m_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
`ifdef ALU_SEQ_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    s_d      = s_q;
    m_d      = m_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    zero_d   = zero_q;
`ifdef ALU_SEQ_OVF_EN
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          opa_d   = opa;
          opb_d   = opb;
          s_d     = s;
          m_d     = m;
          carry_d = cin;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        result_d[{idx_q, 2'b00} +: 4] = alu_f;
        carry_d = alu_c4;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          // Flags are captured with the last nibble so they are valid while done is high.
          idx_d   = '0;
          cout_d  = alu_c4;
          zero_d  = (result_d == '0);
`ifdef ALU_SEQ_OVF_EN
          ovf_d   = 1'b0;
          if (!m_q && s_q == 4'b1001) begin
            ovf_d = (opa_q[W-1] == opb_q[W-1]) && (alu_f[3] != opa_q[W-1]);
          end else if (!m_q && s_q == 4'b0110) begin
            ovf_d = (opa_q[W-1] != opb_q[W-1]) && (alu_f[3] != opa_q[W-1]);
          end
`endif
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign alu_a  = opa_q[{idx_q, 2'b00} +: 4];
  assign alu_b  = opb_q[{idx_q, 2'b00} +: 4];
  assign alu_s  = s_q;
  assign alu_m  = m_q;
  assign alu_c0 = carry_q;

  assign result = result_q;
  assign cout   = cout_q;
  assign zero   = zero_q;
  assign busy   = (state_q == StRun);
  assign done   = (state_q == StDone);
`ifdef ALU_SEQ_OVF_EN
  assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_alu_slice_sequencer.sv
// Bench for alu_slice_sequencer: a behavioural 74181 drives the slice, and a word-level
// model of the same function table predicts result, flags and per-cycle slice inputs.
module tb_alu_slice_sequencer;

  localparam int unsigned N = 4;
  localparam int unsigned W = 4 * N;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] opa, opb;
  logic [3:0]   s;
  logic         m, cin;
  logic [3:0]   alu_a, alu_b, alu_s, alu_f;
  logic         alu_m, alu_c0, alu_c4;
  logic [W-1:0] result;
  logic         cout, zero, busy, done;
`ifdef ALU_SEQ_OVF_EN
  logic         ovf;
`endif

  int total = 0;
  int bad   = 0;

  alu_slice_sequencer #(.NIBBLES(N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .opa    (opa),
    .opb    (opb),
    .s      (s),
    .m      (m),
    .cin    (cin),
    .alu_a  (alu_a),
    .alu_b  (alu_b),
    .alu_s  (alu_s),
    .alu_m  (alu_m),
    .alu_c0 (alu_c0),
    .alu_f  (alu_f),
    .alu_c4 (alu_c4),
    .result (result),
    .cout   (cout),
    .zero   (zero),
    .busy   (busy),
    .done   (done)
`ifdef ALU_SEQ_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 74181 (active-high data, active-low carries) over an arbitrary width; every arithmetic
  // function is X + Y + carry, so a W-bit evaluation equals a chain of 4-bit slices.
  // Returns {carry-out active-low, f}.
  function automatic logic [32:0] ref181(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] fs, input logic fm, input logic cn,
                                         input int bits);
    logic [63:0] mask, aa, bb, x, y, sum, f;
    mask = (64'd1 << bits) - 64'd1;
    aa = {32'd0, a} & mask;
    bb = {32'd0, b} & mask;
    case (fs)
      4'b0000: begin x = aa;        y = 64'd0;    end
      4'b0001: begin x = aa | bb;   y = 64'd0;    end
      4'b0010: begin x = aa | ~bb;  y = 64'd0;    end
      4'b0011: begin x = mask;      y = 64'd0;    end
      4'b0100: begin x = aa;        y = aa & ~bb; end
      4'b0101: begin x = aa | bb;   y = aa & ~bb; end
      4'b0110: begin x = aa;        y = ~bb;      end
      4'b0111: begin x = aa & ~bb;  y = mask;     end
      4'b1000: begin x = aa;        y = aa & bb;  end
      4'b1001: begin x = aa;        y = bb;       end
      4'b1010: begin x = aa | ~bb;  y = aa & bb;  end
      4'b1011: begin x = aa & bb;   y = mask;     end
      4'b1100: begin x = aa;        y = aa;       end
      4'b1101: begin x = aa | bb;   y = aa;       end
      4'b1110: begin x = aa | ~bb;  y = aa;       end
      default: begin x = aa;        y = mask;     end
    endcase
    sum = (x & mask) + (y & mask) + {63'd0, ~cn};
    if (fm) begin
      case (fs)
        4'b0000: f = ~aa;
        4'b0001: f = ~(aa | bb);
        4'b0010: f = ~aa & bb;
        4'b0011: f = 64'd0;
        4'b0100: f = ~(aa & bb);
        4'b0101: f = ~bb;
        4'b0110: f = aa ^ bb;
        4'b0111: f = aa & ~bb;
        4'b1000: f = ~aa | bb;
        4'b1001: f = ~(aa ^ bb);
        4'b1010: f = bb;
        4'b1011: f = aa & bb;
        4'b1100: f = mask;
        4'b1101: f = aa | ~bb;
        4'b1110: f = aa | bb;
        default: f = aa;
      endcase
    end else begin
      f = sum;
    end
    f = f & mask;
    return {~sum[bits], f[31:0]};
  endfunction

  logic [32:0] slice_r;
  assign slice_r = ref181({28'd0, alu_a}, {28'd0, alu_b}, alu_s, alu_m, alu_c0, 4);
  assign alu_f   = slice_r[3:0];
  assign alu_c4  = slice_r[32];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] fs,
                        input logic fm, input logic fcin, input bit poke);
    logic [32:0]  r;
    logic [W-1:0] er;
    logic         ec;
    logic         ez;
`ifdef ALU_SEQ_OVF_EN
    logic         eo;
`endif
    r  = ref181(32'(a), 32'(b), fs, fm, fcin, W);
    er = r[W-1:0];
    ec = r[32];
    ez = (er == '0);
`ifdef ALU_SEQ_OVF_EN
    eo = 1'b0;
    if (!fm && fs == 4'b1001) eo = (a[W-1] == b[W-1]) && (er[W-1] != a[W-1]);
    else if (!fm && fs == 4'b0110) eo = (a[W-1] != b[W-1]) && (er[W-1] != a[W-1]);
`endif
    opa = a; opb = b; s = fs; m = fm; cin = fcin; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < int'(N); k++) begin
      logic [32:0] rc;
      logic        ec0;
      rc  = ref181(32'(a), 32'(b), fs, fm, fcin, 4 * k);
      ec0 = (k == 0) ? fcin : rc[32];
      check("run_busy", 32'(busy), 32'd1);
      check("run_done", 32'(done), 32'd0);
      check("run_alu_a", 32'(alu_a), 32'(a[4*k +: 4]));
      check("run_alu_b", 32'(alu_b), 32'(b[4*k +: 4]));
      check("run_alu_s", 32'(alu_s), 32'(fs));
      check("run_alu_m", 32'(alu_m), 32'(fm));
      check("run_alu_c0", 32'(alu_c0), 32'(ec0));
      if (poke && k == 1) begin
        start = 1'b1;
        opa = W'($urandom);
        opb = W'($urandom);
        s   = ~fs;
        m   = ~fm;
      end
      tick();
      start = 1'b0;
    end
    check("done_pulse", 32'(done), 32'd1);
    check("done_busy", 32'(busy), 32'd0);
    check("result", 32'(result), 32'(er));
    check("cout", 32'(cout), 32'(ec));
    check("zero", 32'(zero), 32'(ez));
`ifdef ALU_SEQ_OVF_EN
    check("ovf", 32'(ovf), 32'(eo));
`endif
    tick();
    check("done_single", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("result_hold", 32'(result), 32'(er));
    check("cout_hold", 32'(cout), 32'(ec));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0;
    opa = '0; opb = '0; s = '0; m = 1'b0; cin = 1'b1;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_cout", 32'(cout), 32'd1);
    check("rst_zero", 32'(zero), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_b", 32'(alu_b), 32'd0);
    check("rst_alu_s", 32'(alu_s), 32'd0);
    check("rst_alu_m", 32'(alu_m), 32'd0);
    check("rst_alu_c0", 32'(alu_c0), 32'd1);
`ifdef ALU_SEQ_OVF_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    run_op(16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b1, 1'b0);
    run_op(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1, 1'b0);
    run_op(16'h5000, 16'h0001, 4'b0110, 1'b0, 1'b0, 1'b0);
    run_op(16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b1, 1'b1);
    run_op(16'h7FFF, 16'h0001, 4'b1001, 1'b0, 1'b1, 1'b0);
    run_op(16'h0001, 16'h0001, 4'b1001, 1'b0, 1'b1, 1'b0);
    run_op(16'h8000, 16'h0001, 4'b0110, 1'b0, 1'b0, 1'b0);

    // Abort an add partway through with a synchronous reset.
    opa = 16'h1111; opb = 16'h2222; s = 4'b1001; m = 1'b0; cin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_alu_c0", 32'(alu_c0), 32'd1);
    check("abort_alu_a", 32'(alu_a), 32'd0);
    check("abort_cout", 32'(cout), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("abort_no_done", 32'(done), 32'd0);
    end
    run_op(16'h0ABC, 16'h1DEF, 4'b1001, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 60; i++) begin
      logic [W-1:0] ra, rb;
      logic [3:0]   rs;
      logic         rm, rc;
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 4'($urandom);
      rm = 1'($urandom);
      rc = 1'($urandom);
      run_op(ra, rb, rs, rm, rc, bit'($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
